// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package loader_pkg;
    typedef enum logic [1:0] {COLLECT, WRITE, DONE} loader_state_t;
    localparam logic [31:0]  LOADER_SENTINEL       = 32'hFFFF_FFFF;
    localparam int unsigned  LOADER_BYTES_PER_WORD = 4;
endpackage

// File: rtl/uart_imem_loader_if.sv
// UART receive stream in, instruction-memory write port out.
interface uart_imem_loader_if #(parameter int unsigned ADDR_W = 8);
    logic              uart_rx_valid;
    logic [7:0]        uart_rx_data;
    logic              uart_rx_break;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  uart_rx_valid, uart_rx_data, uart_rx_break,
        output imem_we, imem_addr, imem_wdata
    );
    modport slave (
        output uart_rx_valid, uart_rx_data, uart_rx_break,
        input  imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/uart_word_assembler.sv
// Little-endian byte-to-word assembler with break clearing.
// Optional partial-word idle timeout under LOADER_TIMEOUT_EN.
module uart_word_assembler
    import loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_break,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        timeout
);
    localparam int unsigned IDX_W  = $clog2(LOADER_BYTES_PER_WORD);
    localparam int unsigned LANE_W = (LOADER_BYTES_PER_WORD - 1) * 8;

    logic [IDX_W-1:0]  byte_idx;
    logic [LANE_W-1:0] lanes;
    logic              accept;
    logic              expire;

    assign accept     = enable && rx_valid && !rx_break;
    assign word_valid = accept && (byte_idx == IDX_W'(LOADER_BYTES_PER_WORD - 1));
    assign word       = {rx_data, lanes};

    // Lanes shift in from the top, so after three bytes lane 0 sits in [7:0]
    // and a restart after break/timeout fully overwrites stale bytes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            byte_idx <= '0;
            lanes    <= '0;
        end else if (enable) begin
            if (rx_break || expire) begin
                byte_idx <= '0;
            end else if (rx_valid) begin
                lanes    <= {rx_data, lanes[LANE_W-1:8]};
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] idle_cnt;

    assign expire = enable && !rx_break && !rx_valid && (byte_idx != '0) &&
                    (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= expire;
            if (!enable || rx_break || rx_valid || (byte_idx == '0) || expire)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: UART bytes -> 32-bit words -> sequential imem writes until sentinel.
// Define LOADER_TIMEOUT_EN to discard partial words after TIMEOUT_CYCLES idle cycles.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 resetn,
    uart_imem_loader_if.master   bus,
    output logic [ADDR_W:0]      word_count,
    output logic                 load_active,
    output logic                 write_done,
    output logic                 overflow,
    output logic                 timeout
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    loader_state_t     state_q, state_d;
    logic [31:0]       asm_word;
    logic              asm_valid;
    logic              latch_word, advance, set_ovf;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       wdata_q;
    logic              ovf_q, active_q;

    uart_word_assembler #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_asm (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (state_q != DONE),
        .rx_valid   (bus.uart_rx_valid),
        .rx_data    (bus.uart_rx_data),
        .rx_break   (bus.uart_rx_break),
        .word       (asm_word),
        .word_valid (asm_valid),
        .timeout    (timeout)
    );

    always_comb begin
        state_d    = state_q;
        latch_word = 1'b0;
        advance    = 1'b0;
        set_ovf    = 1'b0;
        unique case (state_q)
            COLLECT: if (asm_valid) begin
                if (asm_word == LOADER_SENTINEL) begin
                    state_d = DONE;
                end else if (count_q == FULL_COUNT) begin
                    set_ovf = 1'b1;
                    state_d = DONE;
                end else begin
                    latch_word = 1'b1;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                advance = 1'b1;
                state_d = COLLECT;
            end
            DONE:    state_d = DONE;
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= COLLECT;
            addr_q   <= '0;
            count_q  <= '0;
            wdata_q  <= '0;
            ovf_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= (state_d == COLLECT);
            if (latch_word) wdata_q <= asm_word;
            if (advance) begin
                addr_q  <= addr_q + 1'b1;
                count_q <= count_q + 1'b1;
            end
            if (set_ovf) ovf_q <= 1'b1;
        end
    end

    // Strobe is gated by reset so a write caught by a reset edge never lands.
    assign bus.imem_we    = (state_q == WRITE) && resetn;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign word_count     = count_q;
    assign load_active    = active_q;
    assign write_done     = (state_q == DONE);
    assign overflow       = ovf_q;
endmodule
